// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: turns PS/2 key events and two MiSTer joysticks into
// two registered per-player control vectors {coin, start, btn, U, D, L, R}.
// Adds a directional rotation mode, stretched coin pulses and button-0
// autofire.
module arcade_input_mapper #(
    parameter int unsigned NUM_BUTTONS       = 3,           // 1..10
    parameter logic [15:0] COIN_PULSE_CYCLES = 16'd50000,   // >= 1
    parameter logic [19:0] AUTOFIRE_DIV      = 20'd400000,  // >= 1
    parameter bit          COIN_ON_START     = 1'b1
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [64:0]            ps2_key,
    input  logic [15:0]            joystick_0,
    input  logic [15:0]            joystick_1,
    input  logic [1:0]             rotate,
    input  logic                   autofire_en,
    output logic [NUM_BUTTONS+5:0] p1_ctrl,
    output logic [NUM_BUTTONS+5:0] p2_ctrl
);

    localparam int W         = NUM_BUTTONS + 6;
    localparam int START_BIT = NUM_BUTTONS + 4;
    localparam int COIN_BIT  = NUM_BUTTONS + 5;

    // Direction bit positions, shared by joystick and control layouts
    localparam int DIR_R = 0;
    localparam int DIR_L = 1;
    localparam int DIR_D = 2;
    localparam int DIR_U = 3;
    localparam int BTN0  = 4;

    // Per-player key register indices (two keys share button 0)
    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_BTN0A = 4;
    localparam int K_BTN0B = 5;
    localparam int K_BTN1  = 6;
    localparam int K_BTN2  = 7;
    localparam int K_START = 8;
    localparam int K_COIN  = 9;
    localparam int NK      = 10;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_CW   = 2'd1,
        ROT_CCW  = 2'd2,
        ROT_180  = 2'd3
    } rot_e;

    logic                  old_toggle;
    logic                  primed;
    logic                  key_event;
    logic                  key_pressed;
    logic                  key_ext;
    logic [7:0]            key_code;
    logic [1:0][NK-1:0]    key_hit;
    logic [1:0][15:0]      joy;
    logic [1:0][W-1:0]     ctrl_next;
    logic                  unused_joy_bits;

    assign joy = {joystick_1, joystick_0};

    // Pad bits above the coin bit carry nothing for this button count
    assign unused_joy_bits = ^joy;

    // Decode the current key word into per-player key-register hits
    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        key_hit     = '0;
        key_pressed = (ps2_key[15:8] != 8'hF0);
        key_ext     = key_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
        key_code    = (ps2_key[63:24] == 40'd0) ? ps2_key[7:0] : 8'h00;
        case ({key_ext, key_code})
            9'h175:         key_hit[0][K_UP]    = 1'b1;
            9'h172:         key_hit[0][K_DOWN]  = 1'b1;
            9'h16B:         key_hit[0][K_LEFT]  = 1'b1;
            9'h174:         key_hit[0][K_RIGHT] = 1'b1;
            9'h029:         key_hit[0][K_BTN0A] = 1'b1;
            9'h014, 9'h114: key_hit[0][K_BTN0B] = 1'b1;
            9'h011, 9'h111: key_hit[0][K_BTN1]  = 1'b1;
            9'h012:         key_hit[0][K_BTN2]  = 1'b1;
            9'h005:         key_hit[0][K_START] = 1'b1;
            9'h02E:         key_hit[0][K_COIN]  = 1'b1;
            9'h02D:         key_hit[1][K_UP]    = 1'b1;
            9'h02B:         key_hit[1][K_DOWN]  = 1'b1;
            9'h023:         key_hit[1][K_LEFT]  = 1'b1;
            9'h034:         key_hit[1][K_RIGHT] = 1'b1;
            9'h01C:         key_hit[1][K_BTN0A] = 1'b1;
            9'h01B:         key_hit[1][K_BTN1]  = 1'b1;
            9'h015:         key_hit[1][K_BTN2]  = 1'b1;
            9'h006:         key_hit[1][K_START] = 1'b1;
            9'h036:         key_hit[1][K_COIN]  = 1'b1;
            default: ;
        endcase
    end

    // Track the event toggle; the first cycle out of reset only primes it
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_toggle <= 1'b0;
            primed     <= 1'b0;
        end else begin
            old_toggle <= ps2_key[64];
            primed     <= 1'b1;
        end
    end

    assign key_event = primed && (ps2_key[64] != old_toggle);

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [NK-1:0] key_state;
        logic [W-1:0]  kbd;
        logic [W-1:0]  raw;
        logic [W-1:0]  next_ctrl;
        logic          coin_req;
        logic          coin_req_q;
        logic [15:0]   coin_cnt;
        logic [15:0]   coin_cnt_next;
        logic [19:0]   af_cnt;
        logic          af_phase;

        // Key registers: a decoded event writes the pressed state of its key
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                key_state <= '0;
            end else if (key_event) begin
                key_state <= (key_state & ~key_hit[p]) | (key_hit[p] & {NK{key_pressed}});
            end
        end

        // Merge keyboard with joystick and work out the next coin counter
        always_comb begin
            kbd         = '0;
            kbd[DIR_U]  = key_state[K_UP];
            kbd[DIR_D]  = key_state[K_DOWN];
            kbd[DIR_L]  = key_state[K_LEFT];
            kbd[DIR_R]  = key_state[K_RIGHT];
            kbd[BTN0]   = key_state[K_BTN0A] | key_state[K_BTN0B];
            if (NUM_BUTTONS >= 2) kbd[BTN0+1] = key_state[K_BTN1];
            if (NUM_BUTTONS >= 3) kbd[BTN0+2] = key_state[K_BTN2];
            kbd[START_BIT] = key_state[K_START];
            kbd[COIN_BIT]  = key_state[K_COIN];
            raw         = joy[p][W-1:0] | kbd;
            coin_req    = raw[COIN_BIT] | (COIN_ON_START && raw[START_BIT]);
            if (coin_cnt != 16'd0) begin
                coin_cnt_next = coin_cnt - 16'd1;
            end else if (coin_req && !coin_req_q) begin
                coin_cnt_next = COIN_PULSE_CYCLES;
            end else begin
                coin_cnt_next = 16'd0;
            end
        end

        // Coin pulse stretcher and button-0 autofire divider
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                coin_req_q <= 1'b0;
                coin_cnt   <= 16'd0;
                af_cnt     <= 20'd0;
                af_phase   <= 1'b1;
            end else begin
                coin_req_q <= coin_req;
                coin_cnt   <= coin_cnt_next;
                if (!raw[BTN0]) begin
                    af_cnt   <= 20'd0;
                    af_phase <= 1'b1;
                end else if (autofire_en) begin
                    if (af_cnt == AUTOFIRE_DIV - 20'd1) begin
                        af_cnt   <= 20'd0;
                        af_phase <= ~af_phase;
                    end else begin
                        af_cnt <= af_cnt + 20'd1;
                    end
                end
            end
        end

        // Assemble the next control word: rotated directions, gated button 0
        always_comb begin
            next_ctrl = '0;
            case (rot_e'(rotate))
                ROT_CW: begin
                    next_ctrl[DIR_U] = raw[DIR_L];
                    next_ctrl[DIR_D] = raw[DIR_R];
                    next_ctrl[DIR_L] = raw[DIR_D];
                    next_ctrl[DIR_R] = raw[DIR_U];
                end
                ROT_CCW: begin
                    next_ctrl[DIR_U] = raw[DIR_R];
                    next_ctrl[DIR_D] = raw[DIR_L];
                    next_ctrl[DIR_L] = raw[DIR_U];
                    next_ctrl[DIR_R] = raw[DIR_D];
                end
                ROT_180: begin
                    next_ctrl[DIR_U] = raw[DIR_D];
                    next_ctrl[DIR_D] = raw[DIR_U];
                    next_ctrl[DIR_L] = raw[DIR_R];
                    next_ctrl[DIR_R] = raw[DIR_L];
                end
                default: next_ctrl[3:0] = raw[3:0];
            endcase
            next_ctrl[BTN0 +: NUM_BUTTONS] = raw[BTN0 +: NUM_BUTTONS];
            next_ctrl[BTN0]      = raw[BTN0] & (autofire_en ? af_phase : 1'b1);
            next_ctrl[START_BIT] = raw[START_BIT];
            next_ctrl[COIN_BIT]  = (coin_cnt_next != 16'd0);
        end

        assign ctrl_next[p] = next_ctrl;
    end

    // Register both control vectors
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_ctrl <= '0;
            p2_ctrl <= '0;
        end else begin
            p1_ctrl <= ctrl_next[0];
            p2_ctrl <= ctrl_next[1];
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: joystick/rotation vector table plus
// hand-written key, coin, autofire and reset sequences. Expected words are
// queued with a due cycle and compared on the falling edge when due.
module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [64:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic [1:0]  rotate;
    logic        autofire_en;
    logic [8:0]  p1_ctrl;
    logic [8:0]  p2_ctrl;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        string      name;
        logic [8:0] p1;
        logic [8:0] p2;
        int         due;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  rot;
        logic [15:0] j0;
        logic [15:0] j1;
        logic [8:0]  p1;
        logic [8:0]  p2;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];

    arcade_input_mapper #(
        .NUM_BUTTONS      (3),
        .COIN_PULSE_CYCLES(16'd4),
        .AUTOFIRE_DIV     (20'd3),
        .COIN_ON_START    (1'b1)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .rotate     (rotate),
        .autofire_en(autofire_en),
        .p1_ctrl    (p1_ctrl),
        .p2_ctrl    (p2_ctrl)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cycle <= cycle + 1;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void expect_at(input string name, input logic [8:0] p1,
                                      input logic [8:0] p2, input int lat);
        exp_t e;
        e.name = name;
        e.p1   = p1;
        e.p2   = p2;
        e.due  = cycle + lat;
        sb_q.push_back(e);
    endfunction

    // Scoreboard: compare every entry whose due cycle has arrived
    always @(negedge clk_sys) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= cycle) begin
                check({sb_q[i].name, "_p1"}, p1_ctrl, sb_q[i].p1);
                check({sb_q[i].name, "_p2"}, p2_ctrl, sb_q[i].p2);
                sb_q.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic key_event(input logic ext, input logic [7:0] code,
                             input logic pressed, input logic garbage);
        logic [64:0] k;
        k       = '0;
        k[64]   = ~ps2_key[64];
        k[7:0]  = code;
        if (pressed) begin
            k[15:8] = ext ? 8'hE0 : 8'h00;
        end else begin
            k[15:8]  = 8'hF0;
            k[23:16] = ext ? 8'hE0 : 8'h00;
        end
        if (garbage) k[40] = 1'b1;
        ps2_key = k;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"rot0_right",   2'd0, 16'h0001, 16'h0000, 9'h001, 9'h000};
        vecs[1] = '{"rot0_up_left", 2'd0, 16'h0008, 16'h0002, 9'h008, 9'h002};
        vecs[2] = '{"rot1_l_u",     2'd1, 16'h0002, 16'h0008, 9'h008, 9'h001};
        vecs[3] = '{"rot3_l_d",     2'd3, 16'h0002, 16'h0004, 9'h001, 9'h008};
        vecs[4] = '{"rot2_r_u",     2'd2, 16'h0001, 16'h0008, 9'h008, 9'h002};
        vecs[5] = '{"rot1_d_r",     2'd1, 16'h0004, 16'h0001, 9'h002, 9'h004};
        vecs[6] = '{"buttons",      2'd0, 16'h0070, 16'h0050, 9'h070, 9'h050};
        vecs[7] = '{"rot2_multi",   2'd2, 16'h000F, 16'h000C, 9'h00F, 9'h003};
        vecs[8] = '{"upper_bits",   2'd0, 16'hFE00, 16'h8000, 9'h000, 9'h000};

        reset_n     = 1'b0;
        ps2_key     = {1'b1, 40'd0, 24'h00E075};
        joystick_0  = '0;
        joystick_1  = '0;
        rotate      = 2'd0;
        autofire_en = 1'b0;

        // Reset state
        step(3);
        check("reset_p1", p1_ctrl, 9'h000);
        check("reset_p2", p2_ctrl, 9'h000);

        // Release with bit 64 already high: priming only, no event
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) expect_at("prime_no_event", 9'h000, 9'h000, i);
        step(3);

        // Extended up arrow press then release, 2-edge latency
        key_event(1'b1, 8'h75, 1'b1, 1'b0);
        expect_at("up_press_lat1", 9'h000, 9'h000, 1);
        expect_at("up_press_lat2", 9'h008, 9'h000, 2);
        step(2);
        key_event(1'b1, 8'h75, 1'b0, 1'b0);
        expect_at("up_rel_lat1", 9'h008, 9'h000, 1);
        expect_at("up_rel_lat2", 9'h000, 9'h000, 2);
        step(2);

        // Space on btn0; a release with high garbage bits is ignored
        key_event(1'b0, 8'h29, 1'b1, 1'b0);
        expect_at("space_press", 9'h010, 9'h000, 2);
        step(2);
        key_event(1'b0, 8'h29, 1'b0, 1'b1);
        expect_at("garbage_ign1", 9'h010, 9'h000, 1);
        expect_at("garbage_ign2", 9'h010, 9'h000, 2);
        step(2);
        key_event(1'b0, 8'h29, 1'b0, 1'b0);
        expect_at("space_rel", 9'h000, 9'h000, 2);
        step(2);

        // Simultaneous P2 'D' key and joystick right merge by OR
        key_event(1'b0, 8'h23, 1'b1, 1'b0);
        joystick_1 = 16'h0001;
        expect_at("merge_lat1", 9'h000, 9'h001, 1);
        expect_at("merge_lat2", 9'h000, 9'h003, 2);
        step(2);
        key_event(1'b0, 8'h23, 1'b0, 1'b0);
        joystick_1 = 16'h0000;
        expect_at("merge_rel1", 9'h000, 9'h002, 1);
        expect_at("merge_rel2", 9'h000, 9'h000, 2);
        step(2);

        // Joystick and rotation table
        for (int i = 0; i < 9; i++) begin
            rotate     = vecs[i].rot;
            joystick_0 = vecs[i].j0;
            joystick_1 = vecs[i].j1;
            expect_at(vecs[i].name, vecs[i].p1, vecs[i].p2, 1);
            step(1);
        end
        rotate     = 2'd0;
        joystick_0 = '0;
        joystick_1 = '0;
        expect_at("table_clear", 9'h000, 9'h000, 1);
        step(1);

        // '5' held 10 cycles: one 4-cycle coin pulse, no retrigger
        key_event(1'b0, 8'h2E, 1'b1, 1'b0);
        expect_at("coin5_lat1", 9'h000, 9'h000, 1);
        for (int i = 2; i <= 5; i++) expect_at("coin5_high", 9'h100, 9'h000, i);
        for (int i = 6; i <= 11; i++) expect_at("coin5_low", 9'h000, 9'h000, i);
        step(11);
        key_event(1'b0, 8'h2E, 1'b0, 1'b0);
        expect_at("coin5_rel", 9'h000, 9'h000, 2);
        step(2);

        // F2 start also requests a P2 coin
        key_event(1'b0, 8'h06, 1'b1, 1'b0);
        expect_at("f2_lat1", 9'h000, 9'h000, 1);
        for (int i = 2; i <= 5; i++) expect_at("f2_start_coin", 9'h000, 9'h180, i);
        for (int i = 6; i <= 7; i++) expect_at("f2_start_only", 9'h000, 9'h080, i);
        step(7);
        key_event(1'b0, 8'h06, 1'b0, 1'b0);
        expect_at("f2_rel", 9'h000, 9'h000, 2);
        step(2);

        // Autofire on P2 btn0: 111000111000111, then drop enable
        autofire_en = 1'b1;
        joystick_1  = 16'h0010;
        begin
            logic [14:0] pattern;
            pattern = 15'b111000111000111;
            for (int i = 1; i <= 15; i++)
                expect_at("autofire", 9'h000, pattern[15-i] ? 9'h010 : 9'h000, i);
        end
        step(15);
        autofire_en = 1'b0;
        expect_at("af_off_lat1", 9'h000, 9'h010, 1);
        expect_at("af_off_lat2", 9'h000, 9'h010, 2);
        step(2);
        joystick_1 = '0;
        expect_at("af_release", 9'h000, 9'h000, 1);
        step(1);

        // Reset during a coin pulse aborts it asynchronously
        joystick_0 = 16'h0100;
        expect_at("jcoin_start", 9'h100, 9'h000, 1);
        step(1);
        joystick_0 = 16'h0000;
        expect_at("jcoin_rel_holds", 9'h100, 9'h000, 1);
        step(1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midpulse_reset_p1", p1_ctrl, 9'h000);
        check("midpulse_reset_p2", p2_ctrl, 9'h000);
        step(2);
        reset_n = 1'b1;
        expect_at("post_reset_idle", 9'h000, 9'h000, 1);
        step(1);
        joystick_0 = 16'h0100;
        for (int i = 1; i <= 4; i++) expect_at("post_reset_pulse", 9'h100, 9'h000, i);
        for (int i = 5; i <= 6; i++) expect_at("post_reset_hold", 9'h000, 9'h000, i);
        step(6);
        joystick_0 = '0;
        expect_at("final_idle", 9'h000, 9'h000, 1);
        step(3);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
